nios_system_nios2_cpu_mult_pipe: RTL
====================================

Name: nios_system_nios2_cpu_mult_pipe

Overview:
Parametrised, fully pipelined integer multiplier for the Nios II execute/memory path.
- Splits each DATA_W operand into halves and forms four registered HALF_W x HALF_W unsigned partial products, including hi*hi.
- Reduces the partials to the exact 2*DATA_W product, applies signed correction, and returns either the low or the high word per instruction mode.
- Adds valid/tag tracking, global stall, and flush.

Parameters:
DATA_W, 32, operand and result width; must be even and >= 8.
HALF_W, DATA_W/2, partial-product operand width; derived, not overridable.
TAG_W, 5, width of the opaque tag carried alongside each operation (destination register index).

Ports:
clk  in  1  pipeline clock.
reset_n  in  1  asynchronous active-low reset.
en  in  1  global advance enable (stall when 0).
flush  in  1  synchronous kill of all in-flight operations.
in_valid  in  1  operation present on inputs.
in_mode  in  2  0=MUL low, 1=MULXUU high, 2=MULXSS high, 3=MULXSU high.
in_src1  in  DATA_W  operand A.
in_src2  in  DATA_W  operand B.
in_tag  in  TAG_W  opaque tag.
out_valid  out  1  result present.
out_result  out  DATA_W  selected product word.
out_tag  out  TAG_W  tag of the result.
busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (async, reset_n=0): all stage valids=0; out_valid=0, out_result=0, out_tag=0, busy=0; all data registers cleared.
- Accept: an operation enters on a rising edge with en=1, in_valid=1, flush=0. There is no ready signal; the caller holds inputs while en=0.
- Stages:
  - S1 registers ll=A[H-1:0]*B[H-1:0], lh=A[H-1:0]*B[W-1:H], hl=A[W-1:H]*B[H-1:0], hh=A[W-1:H]*B[W-1:H], all unsigned 2H-bit. It also registers mode, tag, valid, A, and B.
  - S2 computes P = ll + (lh<<H) + (hl<<H) + (hh<<W) mod 2^(2W). It then applies correction mod 2^(2W):
    - MULXSS: subtract (A[W-1] ? B<<W : 0) and (B[W-1] ? A<<W : 0).
    - MULXSU: subtract only (A[W-1] ? B<<W : 0).
    - MUL / MULXUU: no correction.
    - P, mode, tag and valid are registered.
  - S3 registers out_result = (mode==0) ? P[W-1:0] : P[2W-1:W], plus out_tag and out_valid.
- Latency: result appears 3 enabled edges after acceptance. Throughput: 1 per enabled cycle.
- MUL low word is mode-independent: signed and unsigned low words are identical.
- en=0: every register, including outputs, holds; out_valid stays as is. A valid result remains visible and is counted once by the consumer when en returns to 1.
- flush=1 (sampled on an edge, regardless of en): all stage valids and out_valid clear on that edge; a same-cycle in_valid is dropped. Data registers may hold stale values; out_result is don't-care when out_valid=0.
- Invalid slots: data registers still load while en=1 but are don't-care; valid bits propagate exactly.
- Reset asserted mid-operation: everything clears immediately, and no result for pre-reset operations ever appears.
- busy = S1.valid | S2.valid | out_valid.
- All arithmetic is exact 2*DATA_W, with no saturation. Overflow wraps mod 2^(2W) only inside correction, and the final P is the exact two's-complement/unsigned product.

Decomposition:
- Package nios_system_nios2_cpu_mult_pkg: mode localparams MODE_MUL=2'd0, MODE_MULXUU=2'd1, MODE_MULXSS=2'd2, MODE_MULXSU=2'd3, and the mode typedef.
- Sub-module nios_system_nios2_cpu_mult_pp: registered unsigned HALF_W x HALF_W multiplier with async clear (from reset_n), clock enable and clk. Instantiated four times for S1, and maps to dedicated DSP multipliers on MAX10.
- S2/S3 and valid/tag control live in the top module.

Test Plan:
1. A=0x0001_0000, B=0x0001_0000, back-to-back MUL then MULXUU with en=1 -> out_valid on edges 3 and 4; results 0x0000_0000 then 0x0000_0001, tags preserved in order.
2. A=B=0xFFFF_FFFF issued in modes MUL, MULXUU, MULXSS, MULXSU:
   - MUL -> 0x0000_0001.
   - MULXUU -> 0xFFFF_FFFE.
   - MULXSS -> 0x0000_0000.
   - MULXSU -> 0xFFFF_FFFF.
3. A=0x8000_0000, B=0x8000_0000 MULXSS -> 0x4000_0000; A=0x8000_0000, B=0x7FFF_FFFF MULXSS -> 0xC000_0000.
4. Issue 3 ops, drop en for 4 cycles after the first edge, then restore -> outputs frozen during the stall; all 3 results emerge in order with correct values; busy stays 1 throughout.
5. Issue 2 ops, assert flush together with a new in_valid on the next edge -> out_valid never asserts for those 3 ops; busy=0 after the flush edge; the next op issues normally with latency 3.
6. Deassert reset_n asynchronously, mid-cycle, with 3 ops in flight -> out_valid, out_result, out_tag and busy are 0 immediately. After release, a random 1000-op sweep matches a reference model for all modes, including DATA_W=16 and TAG_W=3 builds.

Source files
------------

// File: rtl/nios_system_nios2_cpu_mult_pkg.sv
// Shared definitions for the Nios II pipelined multiplier.
// Holds the instruction-mode encoding used by the multiply pipeline and
// by anything that issues operations into it.
package nios_system_nios2_cpu_mult_pkg;

    // Multiply instruction mode carried down the pipeline with each operation.
    typedef logic [1:0] mult_mode_t;

    localparam mult_mode_t MODE_MUL    = 2'd0; // low word, sign-agnostic
    localparam mult_mode_t MODE_MULXUU = 2'd1; // high word, unsigned x unsigned
    localparam mult_mode_t MODE_MULXSS = 2'd2; // high word, signed x signed
    localparam mult_mode_t MODE_MULXSU = 2'd3; // high word, signed x unsigned

endpackage

// File: rtl/nios_system_nios2_cpu_mult_pp.sv
// Registered unsigned HALF_W x HALF_W partial-product multiplier.
// Shaped so that it maps onto one dedicated hardware multiplier with its
// output register absorbed.
// Ports:
//   clk     - clock
//   reset_n - asynchronous active-low clear of the product register
//   en      - clock enable; the product register holds when low
//   a, b    - unsigned HALF_W operands
//   p       - registered 2*HALF_W product
module nios_system_nios2_cpu_mult_pp #(
    parameter int HALF_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [HALF_W-1:0]     a,
    input  logic [HALF_W-1:0]     b,
    output logic [2*HALF_W-1:0]   p
);

    logic [2*HALF_W-1:0] a_ext_s;
    logic [2*HALF_W-1:0] b_ext_s;

    // Zero-extend both operands so the product is computed at full width.
    always_comb begin
        a_ext_s = {{HALF_W{1'b0}}, a};
        b_ext_s = {{HALF_W{1'b0}}, b};
    end

    // Product register: cleared by reset, loaded on enabled edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p <= {(2*HALF_W){1'b0}};
        end else if (en) begin
            p <= a_ext_s * b_ext_s;
        end
    end

endmodule

// File: rtl/nios_system_nios2_cpu_mult_pipe.sv
// Fully pipelined integer multiplier for the Nios II execute/memory path.
//   S1: four registered half-width unsigned partial products, plus the
//       operands, mode, tag and valid.
//   S2: partial-product reduction to the exact 2*DATA_W unsigned product,
//       then signed correction for the MULXSS / MULXSU modes.
//   S3: low or high word selection into the output registers.
// Results appear three enabled edges after acceptance; one operation per
// enabled cycle. DATA_W must be even and at least 8.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   en             - global advance enable (stall when low)
//   flush          - synchronous kill of all in-flight operations
//   in_valid/in_mode/in_src1/in_src2/in_tag - issued operation
//   out_valid/out_result/out_tag            - completed operation
//   busy           - any stage holds a valid operation
module nios_system_nios2_cpu_mult_pipe
    import nios_system_nios2_cpu_mult_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int HALF_W = DATA_W / 2;
    localparam int PROD_W = 2 * DATA_W;

    // S1 state
    logic [DATA_W-1:0] pp_ll_r;
    logic [DATA_W-1:0] pp_lh_r;
    logic [DATA_W-1:0] pp_hl_r;
    logic [DATA_W-1:0] pp_hh_r;
    logic              s1_valid_r;
    mult_mode_t        s1_mode_r;
    logic [TAG_W-1:0]  s1_tag_r;
    logic [DATA_W-1:0] s1_a_r;
    logic [DATA_W-1:0] s1_b_r;

    // S2 combinational and state
    logic [PROD_W-1:0] sum_s;
    logic [PROD_W-1:0] corr_a_s;
    logic [PROD_W-1:0] corr_b_s;
    logic [PROD_W-1:0] p_next_s;
    logic [PROD_W-1:0] s2_p_r;
    logic              s2_valid_r;
    mult_mode_t        s2_mode_r;
    logic [TAG_W-1:0]  s2_tag_r;

    // S3 combinational
    logic [DATA_W-1:0] result_sel_s;

    // Four half-width partial products: ll, lh, hl, hh.
    nios_system_nios2_cpu_mult_pp #(.HALF_W(HALF_W)) u_pp_ll (
        .clk(clk), .reset_n(reset_n), .en(en),
        .a(in_src1[HALF_W-1:0]), .b(in_src2[HALF_W-1:0]), .p(pp_ll_r)
    );
    nios_system_nios2_cpu_mult_pp #(.HALF_W(HALF_W)) u_pp_lh (
        .clk(clk), .reset_n(reset_n), .en(en),
        .a(in_src1[HALF_W-1:0]), .b(in_src2[DATA_W-1:HALF_W]), .p(pp_lh_r)
    );
    nios_system_nios2_cpu_mult_pp #(.HALF_W(HALF_W)) u_pp_hl (
        .clk(clk), .reset_n(reset_n), .en(en),
        .a(in_src1[DATA_W-1:HALF_W]), .b(in_src2[HALF_W-1:0]), .p(pp_hl_r)
    );
    nios_system_nios2_cpu_mult_pp #(.HALF_W(HALF_W)) u_pp_hh (
        .clk(clk), .reset_n(reset_n), .en(en),
        .a(in_src1[DATA_W-1:HALF_W]), .b(in_src2[DATA_W-1:HALF_W]), .p(pp_hh_r)
    );

    // S1 valid: flush wins over enable so a same-edge issue is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (en) begin
            s1_valid_r <= in_valid;
        end
    end

    // S1 side data: loads on every enabled edge, valid or not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_mode_r <= MODE_MUL;
            s1_tag_r  <= {TAG_W{1'b0}};
            s1_a_r    <= {DATA_W{1'b0}};
            s1_b_r    <= {DATA_W{1'b0}};
        end else if (en) begin
            s1_mode_r <= in_mode;
            s1_tag_r  <= in_tag;
            s1_a_r    <= in_src1;
            s1_b_r    <= in_src2;
        end
    end

    // Reduce the partial products to the exact unsigned 2*DATA_W product.
    always_comb begin
        sum_s = {{DATA_W{1'b0}}, pp_ll_r}
              + {{HALF_W{1'b0}}, pp_lh_r, {HALF_W{1'b0}}}
              + {{HALF_W{1'b0}}, pp_hl_r, {HALF_W{1'b0}}}
              + {pp_hh_r, {DATA_W{1'b0}}};
    end

    // Signed correction: a negative operand read as unsigned adds
    // 2^DATA_W times the other operand, which is removed here (mod 2^PROD_W).
    always_comb begin
        corr_a_s = {PROD_W{1'b0}};
        corr_b_s = {PROD_W{1'b0}};
        case (s1_mode_r)
            MODE_MULXSS: begin
                corr_a_s = s1_a_r[DATA_W-1] ? {s1_b_r, {DATA_W{1'b0}}} : {PROD_W{1'b0}};
                corr_b_s = s1_b_r[DATA_W-1] ? {s1_a_r, {DATA_W{1'b0}}} : {PROD_W{1'b0}};
            end
            MODE_MULXSU: begin
                corr_a_s = s1_a_r[DATA_W-1] ? {s1_b_r, {DATA_W{1'b0}}} : {PROD_W{1'b0}};
            end
            MODE_MUL, MODE_MULXUU: begin
                corr_a_s = {PROD_W{1'b0}};
                corr_b_s = {PROD_W{1'b0}};
            end
            default: begin
                corr_a_s = {PROD_W{1'b0}};
                corr_b_s = {PROD_W{1'b0}};
            end
        endcase
        p_next_s = sum_s - corr_a_s - corr_b_s;
    end

    // S2 valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r <= 1'b0;
        end else if (flush) begin
            s2_valid_r <= 1'b0;
        end else if (en) begin
            s2_valid_r <= s1_valid_r;
        end
    end

    // S2 product, mode and tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_p_r    <= {PROD_W{1'b0}};
            s2_mode_r <= MODE_MUL;
            s2_tag_r  <= {TAG_W{1'b0}};
        end else if (en) begin
            s2_p_r    <= p_next_s;
            s2_mode_r <= s1_mode_r;
            s2_tag_r  <= s1_tag_r;
        end
    end

    // Word select: MUL returns the low word, every other mode the high word.
    always_comb begin
        result_sel_s = s2_p_r[PROD_W-1:DATA_W];
        if (s2_mode_r == MODE_MUL) begin
            result_sel_s = s2_p_r[DATA_W-1:0];
        end else begin
            result_sel_s = s2_p_r[PROD_W-1:DATA_W];
        end
    end

    // S3 output valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid_r;
        end
    end

    // S3 output result and tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_result <= {DATA_W{1'b0}};
            out_tag    <= {TAG_W{1'b0}};
        end else if (en) begin
            out_result <= result_sel_s;
            out_tag    <= s2_tag_r;
        end
    end

    // Occupancy indicator built only from stage valid registers.
    assign busy = s1_valid_r | s2_valid_r | out_valid;

endmodule
